// File: rtl/fc_class_selector.sv
// fc_class_selector
// Output-side sequencer for the fully-connected neuron. On start it steps
// class_sel through every output class, one class per cycle, samples the
// neuron score for each class after NEURON_LAT cycles, tracks the running
// maximum and presents the winning class on a valid/ready handshake.
// Ties keep the lower class index and raise the tie flag.

module fc_class_selector #(
  parameter int NUM_CLASSES = 4,
  parameter int IDX_W       = 2,
  parameter int SCORE_W     = 8,
  parameter int NEURON_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               issue_valid,
  output logic [IDX_W-1:0]   class_sel,
  input  logic [SCORE_W-1:0] score_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   winner,
  output logic [SCORE_W-1:0] winner_score,
  output logic               tie
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

  state_t state_r;

  // Delay line that lines up each issued class index with its returning score.
  logic [NEURON_LAT-1:0] dv_r;
  logic [IDX_W-1:0]      didx_r [NEURON_LAT];

  // Score sample and argmax update for the class leaving the delay line.
  logic               samp_s;
  logic [IDX_W-1:0]   sidx_s;
  logic               drain_done_s;
  logic [IDX_W-1:0]   nxt_winner_s;
  logic [SCORE_W-1:0] nxt_score_s;
  logic               nxt_tie_s;

  // Shift issue_valid/class_sel down the delay line, one stage per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_r <= '0;
      for (int i = 0; i < NEURON_LAT; i++) begin
        didx_r[i] <= IDX_ZERO;
      end
    end else begin
      dv_r[0]   <= issue_valid;
      didx_r[0] <= class_sel;
      for (int i = 1; i < NEURON_LAT; i++) begin
        dv_r[i]   <= dv_r[i-1];
        didx_r[i] <= didx_r[i-1];
      end
    end
  end

  // Apply the compare rule to the score that is valid this cycle.
  always_comb begin
    samp_s       = dv_r[NEURON_LAT-1];
    sidx_s       = didx_r[NEURON_LAT-1];
    drain_done_s = (dv_r == '0);
    nxt_winner_s = winner;
    nxt_score_s  = winner_score;
    nxt_tie_s    = tie;
    if (samp_s) begin
      if (sidx_s == IDX_ZERO) begin
        // First class of a frame seeds the maximum unconditionally.
        nxt_winner_s = IDX_ZERO;
        nxt_score_s  = score_in;
        nxt_tie_s    = 1'b0;
      end else if (score_in > winner_score) begin
        nxt_winner_s = sidx_s;
        nxt_score_s  = score_in;
        nxt_tie_s    = 1'b0;
      end else if (score_in == winner_score) begin
        // Equal score: keep the lower index, flag the tie.
        nxt_tie_s    = 1'b1;
      end else begin
        nxt_tie_s    = tie;
      end
    end else begin
      nxt_tie_s = tie;
    end
  end

  // Frame FSM with registered handshake, select and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      busy         <= 1'b0;
      issue_valid  <= 1'b0;
      class_sel    <= IDX_ZERO;
      out_valid    <= 1'b0;
      winner       <= IDX_ZERO;
      winner_score <= '0;
      tie          <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r      <= ST_ISSUE;
            busy         <= 1'b1;
            issue_valid  <= 1'b1;
            class_sel    <= IDX_ZERO;
            winner       <= IDX_ZERO;
            winner_score <= '0;
            tie          <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          winner       <= nxt_winner_s;
          winner_score <= nxt_score_s;
          tie          <= nxt_tie_s;
          if (class_sel == LAST_IDX) begin
            state_r     <= ST_DRAIN;
            issue_valid <= 1'b0;
            class_sel   <= IDX_ZERO;
          end else begin
            class_sel   <= class_sel + IDX_ONE;
          end
        end
        ST_DRAIN: begin
          winner       <= nxt_winner_s;
          winner_score <= nxt_score_s;
          tie          <= nxt_tie_s;
          if (drain_done_s) begin
            // Last delayed score was sampled on the previous edge.
            state_r   <= ST_HOLD;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            state_r   <= ST_DRAIN;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_r   <= ST_IDLE;
            out_valid <= 1'b0;
          end else begin
            state_r   <= ST_HOLD;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          busy        <= 1'b0;
          issue_valid <= 1'b0;
          class_sel   <= IDX_ZERO;
          out_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule
